// File: rtl/sfp_dispatch_pkg.sv
// Shared types and default sizing for the SFP dispatch scheduler.
package sfp_dispatch_pkg;

  localparam int unsigned NUM_QUEUE_DEF = 4;
  localparam int unsigned QID_W_DEF     = 2;
  localparam int unsigned BURST_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARB       = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/sfp_dispatch_sched_rr_arbiter.sv
// Combinational masked-priority round-robin arbiter: lowest set request at or
// above rr_ptr wins, otherwise the lowest set request overall.
module sfp_rr_arbiter
  import sfp_dispatch_pkg::*;
#(
  parameter int unsigned NUM_QUEUE = NUM_QUEUE_DEF,
  parameter int unsigned QID_W     = QID_W_DEF
) (
  input  logic [NUM_QUEUE-1:0] req_i,
  input  logic [QID_W-1:0]     rr_ptr_i,
  output logic [NUM_QUEUE-1:0] grant_c_o,
  output logic [QID_W-1:0]     idx_c_o,
  output logic                 any_c_o
);

  logic [NUM_QUEUE-1:0] hi_mask_c;
  logic [NUM_QUEUE-1:0] masked_c;
  logic [QID_W-1:0]     m_idx_c;
  logic [QID_W-1:0]     r_idx_c;

  always_comb begin
    hi_mask_c = '0;
    for (int unsigned i = 0; i < NUM_QUEUE; i++) begin
      hi_mask_c[i] = (i >= 32'(rr_ptr_i));
    end
    masked_c = req_i & hi_mask_c;
    m_idx_c  = '0;
    r_idx_c  = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = int'(NUM_QUEUE) - 1; i >= 0; i--) begin
      if (masked_c[i]) m_idx_c = QID_W'(i);
      if (req_i[i])    r_idx_c = QID_W'(i);
    end
    any_c_o   = |req_i;
    idx_c_o   = (|masked_c) ? m_idx_c : r_idx_c;
    grant_c_o = any_c_o ? (NUM_QUEUE'(1) << idx_c_o) : '0;
  end

endmodule

// File: rtl/sfp_dispatch_sched.sv
// Round-robin burst scheduler in front of the SFP send path: one grant at a
// time, one dispatch pulse per packet, next packet only after pkt_done.
module sfp_dispatch_sched
  import sfp_dispatch_pkg::*;
#(
  parameter int unsigned NUM_QUEUE = NUM_QUEUE_DEF,
  parameter int unsigned QID_W     = QID_W_DEF,
  parameter int unsigned BURST_W   = BURST_W_DEF
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 kernel_send_start,
  input  logic [NUM_QUEUE-1:0] qune_send_vaild,
  input  logic [BURST_W-1:0]   cfg_burst_len,
  input  logic                 sfp_ready,
  input  logic                 pkt_done,
  output logic                 sfp_dispatch_en,
  output logic [QID_W-1:0]     sfp_dispatch_qid,
  output logic [NUM_QUEUE-1:0] grant_vec,
  output logic                 sched_busy
);

  sched_state_e         state_q, state_d;
  logic [QID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [QID_W-1:0]     qid_q, qid_d;
  logic [NUM_QUEUE-1:0] grant_q, grant_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BURST_W-1:0]   burst_lim_q, burst_lim_d;
  logic                 disp_en_q, disp_en_d;
  logic                 busy_q, busy_d;

  logic [NUM_QUEUE-1:0] arb_grant_c;
  logic [QID_W-1:0]     arb_idx_c;
  logic                 arb_any_c;
  logic                 req_any_c;
  logic                 own_req_c;
  logic                 release_c;
  logic [BURST_W-1:0]   cnt_inc_c;
  logic [QID_W-1:0]     ptr_after_c;

  sfp_rr_arbiter #(
    .NUM_QUEUE (NUM_QUEUE),
    .QID_W     (QID_W)
  ) u_arb (
    .req_i     (qune_send_vaild),
    .rr_ptr_i  (rr_ptr_q),
    .grant_c_o (arb_grant_c),
    .idx_c_o   (arb_idx_c),
    .any_c_o   (arb_any_c)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      qid_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      burst_lim_q <= '0;
      disp_en_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      qid_q       <= qid_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      burst_lim_q <= burst_lim_d;
      disp_en_q   <= disp_en_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    qid_d       = qid_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    burst_lim_d = burst_lim_q;
    disp_en_d   = 1'b0;
    release_c   = 1'b0;
    req_any_c   = |qune_send_vaild;
    own_req_c   = qune_send_vaild[qid_q];
    cnt_inc_c   = (burst_cnt_q == burst_lim_q) ? burst_cnt_q : burst_cnt_q + BURST_W'(1);
    ptr_after_c = (qid_q == QID_W'(NUM_QUEUE - 1)) ? '0 : qid_q + QID_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (kernel_send_start && req_any_c) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (kernel_send_start && arb_any_c) begin
          qid_d       = arb_idx_c;
          grant_d     = arb_grant_c;
          burst_lim_d = (cfg_burst_len == '0) ? BURST_W'(1) : cfg_burst_len;
          burst_cnt_d = '0;
          state_d     = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!kernel_send_start || !own_req_c) begin
          release_c = 1'b1;
        end else if (sfp_ready) begin
          disp_en_d = 1'b1;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (pkt_done) begin
          burst_cnt_d = cnt_inc_c;
          if ((cnt_inc_c == burst_lim_q) || !own_req_c || !kernel_send_start) begin
            release_c = 1'b1;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Release folds into the current cycle; the released queue drops to lowest priority.
    if (release_c) begin
      rr_ptr_d = ptr_after_c;
      grant_d  = '0;
      state_d  = (kernel_send_start && req_any_c) ? ST_ARB : ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign sfp_dispatch_en  = disp_en_q;
  assign sfp_dispatch_qid = qid_q;
  assign grant_vec        = grant_q;
  assign sched_busy       = busy_q;

endmodule

// File: tb/tb_sfp_dispatch_sched.sv
// Self-checking bench for sfp_dispatch_sched: vector table, directed corner
// sequences and randomized traffic against a transaction-level reference.
module tb_sfp_dispatch_sched;

  localparam int NQ = 4;

  logic       ap_clk = 1'b0;
  logic       rst_n, start, ready, done;
  logic [3:0] req, blen;
  logic       sfp_dispatch_en;
  logic [1:0] sfp_dispatch_qid;
  logic [3:0] grant_vec;
  logic       sched_busy;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 ap_clk = ~ap_clk;

  sfp_dispatch_sched dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (rst_n),
    .kernel_send_start (start),
    .qune_send_vaild   (req),
    .cfg_burst_len     (blen),
    .sfp_ready         (ready),
    .pkt_done          (done),
    .sfp_dispatch_en   (sfp_dispatch_en),
    .sfp_dispatch_qid  (sfp_dispatch_qid),
    .grant_vec         (grant_vec),
    .sched_busy        (sched_busy)
  );

  // Reference: who owns the send path, what phase of the packet exchange we are in.
  int m_owner   = 0;
  int m_ptr     = 0;
  int m_cnt     = 0;
  int m_lim     = 1;
  bit m_granted = 0;
  bit m_pending = 0;
  bit m_need_tx = 0;
  bit m_in_fly  = 0;
  bit m_pulse   = 0;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NQ; i++) begin
      int q;
      q = (p + i) % NQ;
      if (r[q]) return q;
    end
    return -1;
  endfunction

  function automatic void model_update();
    bit rel;
    rel     = 0;
    m_pulse = 0;
    if (!rst_n) begin
      m_owner = 0; m_ptr = 0; m_cnt = 0; m_lim = 1;
      m_granted = 0; m_pending = 0; m_need_tx = 0; m_in_fly = 0;
      return;
    end
    if (m_pending) begin
      m_pending = 0;
      if (start && req != 4'd0) begin
        m_owner   = rr_pick(req, m_ptr);
        m_granted = 1;
        m_lim     = (blen == 4'd0) ? 1 : int'(blen);
        m_cnt     = 0;
        m_need_tx = 1;
      end
    end else if (m_need_tx) begin
      if (!start || !req[m_owner]) rel = 1;
      else if (ready) begin
        m_pulse = 1; m_need_tx = 0; m_in_fly = 1;
      end
    end else if (m_in_fly) begin
      if (done) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == m_lim || !req[m_owner] || !start) rel = 1;
        else begin
          m_in_fly = 0; m_need_tx = 1;
        end
      end
    end else if (start && req != 4'd0) begin
      m_pending = 1;
    end
    if (rel) begin
      m_ptr     = (m_owner + 1) % NQ;
      m_granted = 0;
      m_need_tx = 0;
      m_in_fly  = 0;
      m_pending = start && (req != 4'd0);
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    model_update();
    #1;
    chk("en", int'(sfp_dispatch_en), int'(m_pulse));
    chk("qid", int'(sfp_dispatch_qid), m_owner);
    chk("grant", int'(grant_vec), m_granted ? (1 << m_owner) : 0);
    chk("busy", int'(sched_busy), int'(m_pending | m_need_tx | m_in_fly));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; done = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_pulse(input string name);
    bit got;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (sfp_dispatch_en) got = 1;
    end
    if (!got) chk({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic       rst_n, start;
    logic [3:0] req, blen;
    logic       ready, done;
    logic       en;
    logic [1:0] qid;
    logic [3:0] grant;
    logic       busy;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] q, input logic [3:0] b,
                              input logic rd, input logic d, input logic e, input logic [1:0] id,
                              input logic [3:0] g, input logic bz);
    vec_t v;
    v.rst_n = r; v.start = s; v.req = q; v.blen = b; v.ready = rd; v.done = d;
    v.en = e; v.qid = id; v.grant = g; v.busy = bz;
    return v;
  endfunction

  initial begin
    int got_q[$];
    int rr_exp [5];

    rst_n = 1'b0; start = 1'b0; req = '0; blen = '0; ready = 1'b0; done = 1'b0;

    // Single queue 1, burst 3, pkt_done two cycles after each pulse, then rr_ptr=2 probe.
    tbl[0]  = mk(0, 0, 4'b0000, 4'd0, 0, 0, 0, 2'd0, 4'b0000, 0);
    tbl[1]  = mk(1, 1, 4'b0010, 4'd3, 1, 0, 0, 2'd0, 4'b0000, 1);
    tbl[2]  = mk(1, 1, 4'b0010, 4'd3, 1, 0, 0, 2'd1, 4'b0010, 1);
    tbl[3]  = mk(1, 1, 4'b0010, 4'd3, 1, 0, 1, 2'd1, 4'b0010, 1);
    tbl[4]  = mk(1, 1, 4'b0010, 4'd3, 1, 0, 0, 2'd1, 4'b0010, 1);
    tbl[5]  = mk(1, 1, 4'b0010, 4'd3, 1, 1, 0, 2'd1, 4'b0010, 1);
    tbl[6]  = mk(1, 1, 4'b0010, 4'd3, 1, 0, 1, 2'd1, 4'b0010, 1);
    tbl[7]  = mk(1, 1, 4'b0010, 4'd3, 1, 0, 0, 2'd1, 4'b0010, 1);
    tbl[8]  = mk(1, 1, 4'b0010, 4'd3, 1, 1, 0, 2'd1, 4'b0010, 1);
    tbl[9]  = mk(1, 1, 4'b0010, 4'd3, 1, 0, 1, 2'd1, 4'b0010, 1);
    tbl[10] = mk(1, 1, 4'b0010, 4'd3, 1, 0, 0, 2'd1, 4'b0010, 1);
    tbl[11] = mk(1, 1, 4'b0000, 4'd3, 1, 1, 0, 2'd1, 4'b0000, 0);
    tbl[12] = mk(1, 1, 4'b0110, 4'd3, 1, 0, 0, 2'd1, 4'b0000, 1);
    tbl[13] = mk(1, 1, 4'b0110, 4'd3, 1, 0, 0, 2'd2, 4'b0100, 1);
    tbl[14] = mk(1, 1, 4'b0110, 4'd3, 0, 0, 0, 2'd2, 4'b0100, 1);
    tbl[15] = mk(0, 1, 4'b0110, 4'd3, 0, 0, 0, 2'd0, 4'b0000, 0);

    rr_exp = '{0, 1, 2, 3, 0};

    #2;
    for (int r = 0; r < 16; r++) begin
      rst_n = tbl[r].rst_n; start = tbl[r].start; req = tbl[r].req;
      blen = tbl[r].blen; ready = tbl[r].ready; done = tbl[r].done;
      step();
      chk($sformatf("tbl%0d_en", r),    int'(sfp_dispatch_en),  int'(tbl[r].en));
      chk($sformatf("tbl%0d_qid", r),   int'(sfp_dispatch_qid), int'(tbl[r].qid));
      chk($sformatf("tbl%0d_grant", r), int'(grant_vec),        int'(tbl[r].grant));
      chk($sformatf("tbl%0d_busy", r),  int'(sched_busy),       int'(tbl[r].busy));
    end

    // Round-robin fairness with all four queues requesting, burst 1.
    start = 1; req = 4'b1111; blen = 4'd1; ready = 1;
    do_reset();
    for (int c = 0; c < 80 && got_q.size() < 5; c++) begin
      step();
      chk("rr_onehot", int'($onehot0(grant_vec)), 1);
      if (sfp_dispatch_en) got_q.push_back(int'(sfp_dispatch_qid));
      done = sfp_dispatch_en;
    end
    done = 0;
    chk("rr_grants", got_q.size(), 5);
    for (int i = 0; i < got_q.size() && i < 5; i++) chk($sformatf("rr_order%0d", i), got_q[i], rr_exp[i]);

    // Backpressure: no pulse while sfp_ready is low, exactly one once it rises.
    req = 4'b0001; blen = 4'd1; ready = 0;
    do_reset();
    step(); step();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold", int'(sfp_dispatch_en), 0);
    end
    ready = 1;
    step();
    chk("bp_pulse", int'(sfp_dispatch_en), 1);
    step();
    chk("bp_single", int'(sfp_dispatch_en), 0);
    done = 1; step(); done = 0;

    // Queue 2 drains after its second packet; rr_ptr=3 hands the next grant to queue 0.
    req = 4'b0100; blen = 4'd8; ready = 1;
    do_reset();
    wait_pulse("drain_p1");
    chk("drain_qid", int'(sfp_dispatch_qid), 2);
    req = 4'b0111; done = 1; step(); done = 0;
    wait_pulse("drain_p2");
    req = 4'b0011; done = 1; step(); done = 0;
    chk("drain_release", int'(grant_vec), 0);
    step();
    chk("drain_next_qid", int'(sfp_dispatch_qid), 0);
    chk("drain_next_grant", int'(grant_vec), 1);

    // Start drops while waiting for pkt_done: hold, then release straight to idle.
    req = 4'b0001; blen = 4'd4; ready = 1; start = 1;
    do_reset();
    wait_pulse("sd_p1");
    start = 0;
    step(); step();
    chk("sd_no_pulse", int'(sfp_dispatch_en), 0);
    chk("sd_busy_hold", int'(sched_busy), 1);
    done = 1; step(); done = 0;
    chk("sd_idle", int'(sched_busy), 0);
    chk("sd_grant", int'(grant_vec), 0);

    // Reset in the middle of a burst abandons the grant; later pkt_done is ignored.
    start = 1; req = 4'b0010; blen = 4'd4;
    do_reset();
    wait_pulse("rst_p1");
    rst_n = 0; step(); rst_n = 1;
    chk("rst_grant", int'(grant_vec), 0);
    chk("rst_busy", int'(sched_busy), 0);
    req = 4'b0000; done = 1; step(); done = 0;
    chk("rst_done_ignored", int'(sched_busy), 0);
    req = 4'b0011; step(); step();
    chk("rst_restart_qid", int'(sfp_dispatch_qid), 0);

    // Randomized traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blen = 4'($urandom_range(0, 5));
      ready = ($urandom_range(0, 3) != 0);
      done  = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
